// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer selector: layer limits, FSM state
// encoding, and a lowest-set-bit priority encoder.
package layer_pkg;

    localparam int MAX_LAYERS = 16;
    localparam int MAX_IDX_W  = $clog2(MAX_LAYERS);

    typedef enum logic {
        LATCHED   = 1'b0,
        MOMENTARY = 1'b1
    } layer_state_e;

    // Lowest index wins when several select bits are set; all-zero maps to 0.
    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_LAYERS-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/layer_select_fsm_rise_detect.sv
// Registered rising-edge detector for a level button. A button still held
// when reset releases must be seen low once before it can produce an edge.
module rise_detect (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic armed;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset is in the sensitivity list to make it asynchronous.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q <= d;
            if (!d) armed <= 1'b1;
        end
    end

    assign rise = d & ~d_q & armed;

endmodule

// File: rtl/layer_select_fsm.sv
// Keyboard-style layer selector: direct select and step buttons move a latched
// base layer; with LAYER_SEL_MOMENTARY_EN defined, held mom_req bits override it.
module layer_select_fsm
    import layer_pkg::*;
#(
    parameter  int NUM_LAYERS = 3,
    parameter  int WRAP       = 1,
    localparam int IDX_W      = ($clog2(NUM_LAYERS) > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_LAYERS-1:0] req,
    input  logic                  step_up,
    input  logic                  step_dn,
    input  logic [NUM_LAYERS-1:0] mom_req,
    output logic [NUM_LAYERS-1:0] layer_onehot,
    output logic [IDX_W-1:0]      layer_idx,
    output logic [IDX_W-1:0]      base_idx,
    output logic                  changed
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_LAYERS - 1);

    logic             up_rise;
    logic             dn_rise;
    logic [IDX_W-1:0] base_d;
    logic [IDX_W-1:0] layer_d;

    rise_detect u_up_detect (
        .clk    (clk),
        .resetn (resetn),
        .d      (step_up),
        .rise   (up_rise)
    );

    rise_detect u_dn_detect (
        .clk    (clk),
        .resetn (resetn),
        .d      (step_dn),
        .rise   (dn_rise)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        base_d = base_idx;
        if (req != '0) begin
            base_d = IDX_W'(lowest_set_idx(MAX_LAYERS'(req)));
        end else if (up_rise && !dn_rise) begin
            if (base_idx != TOP_IDX) base_d = base_idx + IDX_W'(1);
            else if (WRAP != 0)      base_d = '0;
        end else if (dn_rise && !up_rise) begin
            if (base_idx != '0)      base_d = base_idx - IDX_W'(1);
            else if (WRAP != 0)      base_d = TOP_IDX;
        end
    end

`ifdef LAYER_SEL_MOMENTARY_EN
    layer_state_e state;
    layer_state_e state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= LATCHED;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            LATCHED:   if (mom_req != '0) state_d = MOMENTARY;
            MOMENTARY: if (mom_req == '0) state_d = LATCHED;
            default:   state_d = LATCHED;
        endcase
    end

    // Output follows the state being entered so a press shows after one edge,
    // and a release lands on the base value written at that same edge.
    always_comb begin
        layer_d = base_d;
        if (state_d == MOMENTARY) layer_d = IDX_W'(lowest_set_idx(MAX_LAYERS'(mom_req)));
    end
`else
    logic unused_mom_req;
    assign unused_mom_req = ^mom_req;

    always_comb begin
        layer_d = base_d;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            base_idx     <= '0;
            layer_idx    <= '0;
            layer_onehot <= NUM_LAYERS'(1);
            changed      <= 1'b0;
        end else begin
            base_idx     <= base_d;
            layer_idx    <= layer_d;
            layer_onehot <= NUM_LAYERS'(1) << layer_d;
            changed      <= (layer_d != layer_idx);
        end
    end

endmodule

// File: tb/tb_layer_select_fsm.sv
// Self-checking bench for layer_select_fsm: a vector table plus hand-written
// sequences; momentary cases run only when LAYER_SEL_MOMENTARY_EN is defined.
module tb_layer_select_fsm;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] req3 = '0, mom3 = '0;
    logic       up3 = 1'b0, dn3 = 1'b0;
    logic [2:0] oh3;
    logic [1:0] idx3, base3;
    logic       ch3;

    logic [3:0] req4 = '0, mom4 = '0;
    logic       up4 = 1'b0, dn4 = 1'b0;
    logic [3:0] oh4w, oh4s;
    logic [1:0] idx4w, base4w, idx4s, base4s;
    logic       ch4w, ch4s;

    layer_select_fsm #(.NUM_LAYERS(3), .WRAP(1)) dut3 (
        .clk(clk), .resetn(resetn), .req(req3), .step_up(up3), .step_dn(dn3),
        .mom_req(mom3), .layer_onehot(oh3), .layer_idx(idx3), .base_idx(base3),
        .changed(ch3));

    layer_select_fsm #(.NUM_LAYERS(4), .WRAP(1)) dut4w (
        .clk(clk), .resetn(resetn), .req(req4), .step_up(up4), .step_dn(dn4),
        .mom_req(mom4), .layer_onehot(oh4w), .layer_idx(idx4w), .base_idx(base4w),
        .changed(ch4w));

    layer_select_fsm #(.NUM_LAYERS(4), .WRAP(0)) dut4s (
        .clk(clk), .resetn(resetn), .req(req4), .step_up(up4), .step_dn(dn4),
        .mom_req(mom4), .layer_onehot(oh4s), .layer_idx(idx4s), .base_idx(base4s),
        .changed(ch4s));

    typedef struct packed {
        logic [3:0] idx;
        logic [3:0] base;
        logic       ch;
    } exp_t;

    typedef struct {
        logic [2:0] req;
        logic       up;
        logic       dn;
        logic [2:0] mom;
        int         idx;
        int         base;
        int         ch;
    } vec_t;

    exp_t q3[$];
    exp_t q4w[$];
    exp_t q4s[$];
    vec_t tbl[16];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_outs(input string tag, input exp_t e, input logic [31:0] idx,
                                input logic [31:0] oh, input logic [31:0] base, input logic ch);
        check({tag, " layer_idx"}, idx, 32'(e.idx));
        check({tag, " layer_onehot"}, oh, 32'd1 << e.idx);
        check({tag, " base_idx"}, base, 32'(e.base));
        check({tag, " changed"}, 32'(ch), 32'(e.ch));
    endtask

    task automatic step3(input string tag, input logic [2:0] r, input logic u, input logic d,
                         input logic [2:0] m, input int ei, input int eb, input int ec);
        exp_t e;
        @(negedge clk);
        req3 = r; up3 = u; dn3 = d; mom3 = m;
        q3.push_back('{idx: 4'(ei), base: 4'(eb), ch: 1'(ec)});
        @(posedge clk);
        #1;
        e = q3.pop_front();
        compare_outs(tag, e, 32'(idx3), 32'(oh3), 32'(base3), ch3);
    endtask

    task automatic step4(input string tag, input logic [3:0] r, input logic u, input logic d,
                         input int wi, input int wc, input int si, input int sc);
        exp_t e;
        @(negedge clk);
        req4 = r; up4 = u; dn4 = d; mom4 = '0;
        q4w.push_back('{idx: 4'(wi), base: 4'(wi), ch: 1'(wc)});
        q4s.push_back('{idx: 4'(si), base: 4'(si), ch: 1'(sc)});
        @(posedge clk);
        #1;
        e = q4w.pop_front();
        compare_outs({tag, " wrap"}, e, 32'(idx4w), 32'(oh4w), 32'(base4w), ch4w);
        e = q4s.pop_front();
        compare_outs({tag, " sat"}, e, 32'(idx4s), 32'(oh4s), 32'(base4s), ch4s);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " idx3"}, 32'(idx3), 32'd0);
        check({tag, " oh3"}, 32'(oh3), 32'd1);
        check({tag, " base3"}, 32'(base3), 32'd0);
        check({tag, " ch3"}, 32'(ch3), 32'd0);
        check({tag, " idx4w"}, 32'(idx4w), 32'd0);
        check({tag, " oh4s"}, 32'(oh4s), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req     up    dn    mom     idx base ch
        tbl[0]  = '{3'b010, 1'b0, 1'b0, 3'b000, 1, 1, 1};
        tbl[1]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0};
        tbl[2]  = '{3'b010, 1'b0, 1'b0, 3'b000, 1, 1, 0};
        tbl[3]  = '{3'b001, 1'b0, 1'b0, 3'b000, 0, 0, 1};
        tbl[4]  = '{3'b110, 1'b1, 1'b0, 3'b000, 1, 1, 1};
        tbl[5]  = '{3'b000, 1'b1, 1'b0, 3'b000, 1, 1, 0};
        tbl[6]  = '{3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0};
        tbl[7]  = '{3'b000, 1'b1, 1'b0, 3'b000, 2, 2, 1};
        tbl[8]  = '{3'b000, 1'b0, 1'b0, 3'b000, 2, 2, 0};
        tbl[9]  = '{3'b000, 1'b1, 1'b0, 3'b000, 0, 0, 1};
        tbl[10] = '{3'b000, 1'b0, 1'b1, 3'b000, 2, 2, 1};
        tbl[11] = '{3'b000, 1'b0, 1'b0, 3'b000, 2, 2, 0};
        tbl[12] = '{3'b000, 1'b1, 1'b1, 3'b000, 2, 2, 0};
        tbl[13] = '{3'b000, 1'b0, 1'b0, 3'b000, 2, 2, 0};
        tbl[14] = '{3'b000, 1'b0, 1'b1, 3'b000, 1, 1, 1};
        tbl[15] = '{3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0};

        #1 resetn = 1'b0;
        #3 check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step3($sformatf("vec%0d", i), tbl[i].req, tbl[i].up, tbl[i].dn, tbl[i].mom,
                  tbl[i].idx, tbl[i].base, tbl[i].ch);
        end

        // Held step_up: one increment over ten cycles.
        step3("hold0", 3'b000, 1'b1, 1'b0, 3'b000, 2, 2, 1);
        for (int i = 1; i < 10; i++) begin
            step3($sformatf("hold%0d", i), 3'b000, 1'b1, 1'b0, 3'b000, 2, 2, 0);
        end
        step3("hold_rel", 3'b000, 1'b0, 1'b0, 3'b000, 2, 2, 0);

`ifdef LAYER_SEL_MOMENTARY_EN
        step3("mom_base0", 3'b001, 1'b0, 1'b0, 3'b000, 0, 0, 1);
        step3("mom_press", 3'b000, 1'b0, 1'b0, 3'b100, 2, 0, 1);
        step3("mom_step", 3'b000, 1'b1, 1'b0, 3'b100, 2, 1, 0);
        step3("mom_hold", 3'b000, 1'b0, 1'b0, 3'b100, 2, 1, 0);
        step3("mom_release", 3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 1);
        step3("mom_idle", 3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0);
        step3("mom_low2", 3'b000, 1'b0, 1'b0, 3'b011, 0, 1, 1);
        step3("mom_track", 3'b000, 1'b0, 1'b0, 3'b010, 1, 1, 1);
        step3("mom_same_rel", 3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0);
`endif

        // Reset mid-momentary with step_up held through release.
        @(negedge clk);
        req3 = 3'b010; up3 = 1'b0; mom3 = 3'b000;
        @(negedge clk);
        req3 = 3'b000; mom3 = 3'b100; up3 = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_reset_state("mid_reset");
        @(negedge clk);
        resetn = 1'b1;
        mom3 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            step3($sformatf("post_rst_held%0d", i), 3'b000, 1'b1, 1'b0, 3'b000, 0, 0, 0);
        end
        step3("post_rst_rel", 3'b000, 1'b0, 1'b0, 3'b000, 0, 0, 0);
        step3("post_rst_press", 3'b000, 1'b1, 1'b0, 3'b000, 1, 1, 1);
        step3("post_rst_idle", 3'b000, 1'b0, 1'b0, 3'b000, 1, 1, 0);

        // Four layers: wrap vs saturate at both ends.
        step4("n4_top", 4'b1000, 1'b0, 1'b0, 3, 1, 3, 1);
        step4("n4_idle", 4'b0000, 1'b0, 1'b0, 3, 0, 3, 0);
        step4("n4_up_top", 4'b0000, 1'b1, 1'b0, 0, 1, 3, 0);
        step4("n4_up_rel", 4'b0000, 1'b0, 1'b0, 0, 0, 3, 0);
        step4("n4_bottom", 4'b0001, 1'b0, 1'b0, 0, 0, 0, 1);
        step4("n4_dn_bot", 4'b0000, 1'b0, 1'b1, 3, 1, 0, 0);
        step4("n4_dn_rel", 4'b0000, 1'b0, 1'b0, 3, 0, 0, 0);
        step4("n4_dn_mid", 4'b0000, 1'b0, 1'b1, 2, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_select_fsm.md
LAYER_SELECT_FSM -- requirements
Module: layer_select_fsm

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, number of selectable layers (legal 2..16).
REQ-002 SHALL have parameter WRAP, default 1, step wraps around when 1 and saturates at the ends when 0.
REQ-003 SHALL derive local IDX_W = max(1, clog2(NUM_LAYERS)).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req  input  NUM_LAYERS  direct layer select, level-sensitive, bit i selects layer i.
REQ-007 SHALL have port step_up  input  1  level button, rising edge advances one layer.
REQ-008 SHALL have port step_dn  input  1  level button, rising edge retreats one layer.
REQ-009 SHALL have port mom_req  input  NUM_LAYERS  momentary hold select, active while held.
REQ-010 SHALL have port layer_onehot  output  NUM_LAYERS  active layer, one-hot, registered.
REQ-011 SHALL have port layer_idx  output  IDX_W  active layer index, registered, consistent with layer_onehot.
REQ-012 SHALL have port base_idx  output  IDX_W  latched base layer index, registered.
REQ-013 SHALL have port changed  output  1  one-cycle pulse when layer_idx changes.

Function
REQ-014 SHALL hold base_idx as the latched layer; direct select and step update only base_idx.
REQ-015 SHALL, when req is nonzero, load base_idx with the lowest set bit index of req; this takes priority over steps.
REQ-016 SHALL ignore req when it is all zero.
REQ-017 SHALL detect step edges as step & ~step_q, with step_q registered each cycle.
REQ-018 SHALL, on a step_up edge alone, set base_idx to base_idx+1; at NUM_LAYERS-1 it goes to 0 (WRAP=1) or holds (WRAP=0).
REQ-019 SHALL, on a step_dn edge alone, set base_idx to base_idx-1; at 0 it goes to NUM_LAYERS-1 (WRAP=1) or holds (WRAP=0).
REQ-020 SHALL make no base change when step_up and step_dn edges occur in the same cycle.
REQ-021 SHALL have latency of one edge: an input sampled at edge N is reflected on the outputs after edge N.
REQ-022 SHALL, with the macro enabled, run a two-state FSM:
  - LATCHED: layer_idx = base_idx.
  - MOMENTARY: layer_idx = lowest set bit index of mom_req.
REQ-023 SHALL transition LATCHED->MOMENTARY when mom_req != 0, and MOMENTARY->LATCHED when mom_req == 0; on return, layer_idx equals the current base_idx.
REQ-024 SHALL, in MOMENTARY, track changes of the lowest held mom_req bit every cycle.
REQ-025 SHALL continue to accept req and step updates to base_idx while in MOMENTARY.
REQ-026 SHALL assert changed for exactly one cycle after any edge where the registered layer_idx takes a new value; no pulse for a same-value reload.
REQ-027 SHALL always drive layer_onehot as 1 << layer_idx; it is never zero and never multi-hot.

Reset
REQ-028 SHALL, while resetn=0, immediately force:
  - base_idx=0, layer_idx=0
  - layer_onehot = one-hot bit 0
  - changed=0
  - step_q=0
  - FSM state LATCHED
REQ-029 SHALL, on reset assertion mid-momentary, discard the momentary state; after release, a still-held step button produces no edge until it is released and pressed again.

Configuration
REQ-030 SHALL use macro LAYER_SEL_MOMENTARY_EN: when defined, mom_req and the MOMENTARY state are compiled in; when undefined, mom_req is present but ignored, the FSM is absent, and layer_idx always equals base_idx.

Structure
REQ-031 SHALL place a shared package layer_pkg holding MAX_LAYERS=16, the FSM state enum (LATCHED, MOMENTARY), and a lowest-set-bit priority-encode function.
REQ-032 SHALL instantiate sub-module rise_detect twice (step_up, step_dn): a 1-bit registered rising-edge detector with clk/resetn.

Verification
REQ-033 SHALL cover: NUM_LAYERS=3, reset, then req=3'b010 for 1 cycle -> layer_idx=1, layer_onehot=3'b010, changed pulses once.
REQ-034 SHALL cover: NUM_LAYERS=4, WRAP=1, base=3, step_up pulse -> layer_idx=0; same with WRAP=0 -> stays 3, changed stays 0.
REQ-035 SHALL cover: req=3'b110 with a simultaneous step_up edge -> layer_idx=1 (req priority, lowest bit wins).
REQ-036 SHALL cover: step_up and step_dn rising in the same cycle -> no change; step_up held high for 10 cycles -> exactly one increment.
REQ-037 SHALL cover, with LAYER_SEL_MOMENTARY_EN: base=0, mom_req=3'b100 held, step_up during hold -> layer_idx=2 throughout; release -> layer_idx=1, and changed pulses on each transition.
REQ-038 SHALL cover: resetn asserted mid-momentary with step_up held -> outputs reset at once; after release with step_up still high, no increment.
